depth_engine_scheduler: RTL and testbench

//  Shares NUM_ENGINES Mandelbrot depth-calculator engines across one pixel stream.

---
 rtl/mandel_pkg.sv | 24 ++
 rtl/engine_slot.sv | 47 ++++
 rtl/depth_engine_scheduler.sv | 111 +++++++++++
 tb/tb_depth_engine_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types and default geometry for the Mandelbrot pixel generator.
// Slots carry their state, the raster tag of the dispatched pixel and its depth.
package mandel_pkg;

  localparam int X_SIZE  = 640;
  localparam int Y_SIZE  = 480;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int DEPTH_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } slot_state_t;

  typedef struct packed {
    slot_state_t          state;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [DEPTH_W-1:0]   depth;
  } slot_t;

endpackage

// File: rtl/engine_slot.sv
// Bookkeeping for one depth engine: IDLE/BUSY/DONE state, pixel tag, latched depth
// and a sticky flag for done pulses that arrive when the engine was not started.
module engine_slot
  import mandel_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               dispatch_i,
  input  logic [X_W-1:0]     tag_x_i,
  input  logic [Y_W-1:0]     tag_y_i,
  input  logic               done_i,
  input  logic [DEPTH_W-1:0] depth_i,
  input  logic               retire_i,
  output slot_t              slot_o,
  output logic               proto_err_o
);

  slot_t slot_q;
  logic  err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
      err_q  <= 1'b0;
    end else begin
      // A done pulse outside BUSY is flagged but never changes the slot.
      if (done_i && (slot_q.state != BUSY)) err_q <= 1'b1;
      case (slot_q.state)
        IDLE: if (dispatch_i) begin
          slot_q.state <= BUSY;
          slot_q.x     <= tag_x_i;
          slot_q.y     <= tag_y_i;
        end
        BUSY: if (done_i) begin
          slot_q.state <= DONE;
          slot_q.depth <= depth_i;
        end
        DONE: if (retire_i) slot_q.state <= IDLE;
        default: slot_q.state <= IDLE;
      endcase
    end
  end

  assign slot_o      = slot_q;
  assign proto_err_o = err_q;

endmodule

// File: rtl/depth_engine_scheduler.sv
// Round-robin dispatch of raster pixels to NUM_ENGINES depth engines with strictly
// in-order retirement, so the output stream stays in raster order for any latencies.
module depth_engine_scheduler
  import mandel_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = mandel_pkg::X_SIZE,
  parameter int Y_SIZE      = mandel_pkg::Y_SIZE
) (
  input  logic                           out_stream_aclk,
  input  logic                           periph_resetn,
  input  logic                           run,
  output logic [NUM_ENGINES-1:0]         eng_start,
  output logic [X_W-1:0]                 eng_x,
  output logic [Y_W-1:0]                 eng_y,
  input  logic [NUM_ENGINES-1:0]         eng_done,
  input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [DEPTH_W-1:0]             pix_depth,
  output logic [X_W-1:0]                 pix_x,
  output logic [Y_W-1:0]                 pix_y,
  output logic                           pix_sof,
  output logic                           pix_eol,
  output logic                           frame_done,
  output logic                           proto_err
);

  localparam int             PTR_W  = $clog2(NUM_ENGINES);
  localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE - 1);

  slot_t                  slots [NUM_ENGINES];
  logic [NUM_ENGINES-1:0] slot_err;
  logic [NUM_ENGINES-1:0] dispatch_v;
  logic [NUM_ENGINES-1:0] retire_v;

  logic [PTR_W-1:0]       d_ptr_q, r_ptr_q;
  logic [X_W-1:0]         x_q, eng_x_q;
  logic [Y_W-1:0]         y_q, eng_y_q;
  logic [NUM_ENGINES-1:0] eng_start_q;

  logic  fire, retire;
  slot_t r_slot;

  // A slot freed by retire only reads IDLE from the next cycle, so it cannot be
  // re-dispatched in its own retire cycle.
  assign fire   = run && (slots[d_ptr_q].state == IDLE);
  assign r_slot = slots[r_ptr_q];
  assign retire = pix_valid && pix_ready;

  for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_slot
    assign dispatch_v[i] = fire   && (d_ptr_q == PTR_W'(i));
    assign retire_v[i]   = retire && (r_ptr_q == PTR_W'(i));

    engine_slot u_slot (
      .clk_i       (out_stream_aclk),
      .rst_ni      (periph_resetn),
      .dispatch_i  (dispatch_v[i]),
      .tag_x_i     (x_q),
      .tag_y_i     (y_q),
      .done_i      (eng_done[i]),
      .depth_i     (eng_depth[i*DEPTH_W +: DEPTH_W]),
      .retire_i    (retire_v[i]),
      .slot_o      (slots[i]),
      .proto_err_o (slot_err[i])
    );
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      d_ptr_q     <= '0;
      r_ptr_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      eng_start_q <= '0;
    end else begin
      eng_start_q <= '0;
      if (fire) begin
        eng_start_q <= NUM_ENGINES'(1) << d_ptr_q;
        eng_x_q     <= x_q;
        eng_y_q     <= y_q;
        d_ptr_q     <= d_ptr_q + PTR_W'(1);
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
        end else begin
          x_q <= x_q + X_W'(1);
        end
      end
      if (retire) r_ptr_q <= r_ptr_q + PTR_W'(1);
    end
  end

  assign eng_start  = eng_start_q;
  assign eng_x      = eng_x_q;
  assign eng_y      = eng_y_q;

  // Retire outputs come straight from slot registers; pix_ready only steers state.
  assign pix_valid  = (r_slot.state == DONE);
  assign pix_depth  = r_slot.depth;
  assign pix_x      = r_slot.x;
  assign pix_y      = r_slot.y;
  assign pix_sof    = pix_valid && (r_slot.x == '0) && (r_slot.y == '0);
  assign pix_eol    = pix_valid && (r_slot.x == X_LAST);
  assign frame_done = retire && (r_slot.x == X_LAST) && (r_slot.y == Y_LAST);
  assign proto_err  = |slot_err;

endmodule

// File: tb/tb_depth_engine_scheduler.sv
// Directed bench for depth_engine_scheduler on a 4x2 frame with a behavioural
// engine array of programmable per-engine latency.
module tb_depth_engine_scheduler;

  localparam int NE = 4;
  localparam int XS = 4;
  localparam int YS = 2;
  localparam int DW = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            run = 1'b0;
  logic            pix_ready = 1'b1;
  logic [NE-1:0]   eng_start, eng_done, inj;
  logic [9:0]      eng_x, pix_x, pix_depth;
  logic [8:0]      eng_y, pix_y;
  logic [NE*DW-1:0] eng_depth;
  logic            pix_valid, pix_sof, pix_eol, frame_done, proto_err;

  typedef struct packed { logic [1:0] eng; logic [9:0] x; logic [8:0] y; } disp_t;
  typedef struct packed { logic [9:0] x; logic [8:0] y; logic [9:0] d; logic sof, eol, fd; } ret_t;

  disp_t dq[$];
  ret_t  rq[$];
  int    done_order[$];
  int    fd_cnt = 0;
  int    lat [NE];
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  depth_engine_scheduler #(.NUM_ENGINES(NE), .X_SIZE(XS), .Y_SIZE(YS)) dut (
    .out_stream_aclk (clk),
    .periph_resetn   (rst_n),
    .run             (run),
    .eng_start       (eng_start),
    .eng_x           (eng_x),
    .eng_y           (eng_y),
    .eng_done        (eng_done),
    .eng_depth       (eng_depth),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_depth       (pix_depth),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_sof         (pix_sof),
    .pix_eol         (pix_eol),
    .frame_done      (frame_done),
    .proto_err       (proto_err)
  );

  function automatic logic [9:0] depth_of(input logic [9:0] x, input logic [8:0] y);
    return 10'(int'(x) * 7 + int'(y) * 13 + 5);
  endfunction

  function automatic disp_t exp_disp(input int k);
    disp_t r;
    r.eng = 2'(k % NE);
    r.x   = 10'(k % XS);
    r.y   = 9'((k / XS) % YS);
    return r;
  endfunction

  function automatic ret_t exp_ret(input int k);
    ret_t r;
    r.x   = 10'(k % XS);
    r.y   = 9'((k / XS) % YS);
    r.d   = depth_of(r.x, r.y);
    r.sof = (r.x == 0) && (r.y == 0);
    r.eol = (r.x == 10'(XS - 1));
    r.fd  = r.eol && (r.y == 9'(YS - 1));
    return r;
  endfunction

  // Engine array: each engine answers lat[i] cycles after its start pulse.
  initial begin : engines
    int          cnt [NE];
    logic        bsy [NE];
    logic [9:0]  ex [NE];
    logic [8:0]  ey [NE];
    logic [NE-1:0] dn;
    eng_done  = '0;
    eng_depth = '0;
    for (int i = 0; i < NE; i++) begin bsy[i] = 1'b0; cnt[i] = 0; ex[i] = '0; ey[i] = '0; end
    forever begin
      @(negedge clk);
      dn = '0;
      if (!rst_n) begin
        for (int i = 0; i < NE; i++) bsy[i] = 1'b0;
      end else begin
        for (int i = 0; i < NE; i++) begin
          if (bsy[i]) begin
            cnt[i] = cnt[i] - 1;
            if (cnt[i] <= 0) begin
              dn[i] = 1'b1;
              bsy[i] = 1'b0;
              eng_depth[i*DW +: DW] = depth_of(ex[i], ey[i]);
              done_order.push_back(i);
            end
          end
          if (eng_start[i]) begin
            bsy[i] = 1'b1; cnt[i] = lat[i]; ex[i] = eng_x; ey[i] = eng_y;
          end
        end
      end
      eng_done = dn | inj;
    end
  end

  // Log every dispatch and every retire handshake.
  initial begin : monitor
    disp_t d;
    ret_t  r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (|eng_start) begin
          d.eng = '0;
          for (int i = 0; i < NE; i++) if (eng_start[i]) d.eng = 2'(i);
          d.x = eng_x; d.y = eng_y;
          dq.push_back(d);
        end
        if (pix_valid && pix_ready) begin
          r.x = pix_x; r.y = pix_y; r.d = pix_depth;
          r.sof = pix_sof; r.eol = pix_eol; r.fd = frame_done;
          rq.push_back(r);
        end
        if (frame_done) fd_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; pix_ready = 1'b1; inj = '0;
    step(3);
    dq.delete(); rq.delete(); done_order.delete(); fd_cnt = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_ret(input int n, input int budget, input string tag);
    int c = 0;
    while (rq.size() < n && c < budget) begin step(1); c++; end
    chk({tag, "_ret_timeout"}, 64'(rq.size() >= n), 64'(1));
  endtask

  task automatic drain(input string tag);
    int c = 0;
    run = 1'b0;
    while (rq.size() != dq.size() && c < 300) begin step(1); c++; end
    step(2);
    chk({tag, "_drain"}, 64'(rq.size()), 64'(dq.size()));
  endtask

  task automatic check_streams(input string tag);
    for (int k = 0; k < dq.size(); k++)
      chk($sformatf("%s_disp%0d", tag, k), 64'(dq[k]), 64'(exp_disp(k)));
    for (int k = 0; k < rq.size(); k++)
      chk($sformatf("%s_ret%0d", tag, k), 64'(rq[k]), 64'(exp_ret(k)));
  endtask

  initial begin : stim
    int c;
    inj = '0;
    set_lat(5, 5, 5, 5);

    // Reset state
    #2 rst_n = 1'b0;
    step(2);
    chk("reset_outputs", 64'({eng_start, eng_x, eng_y, pix_valid, pix_depth, pix_x, pix_y,
                              pix_sof, pix_eol, frame_done, proto_err}), 64'(0));

    // 1: fixed latency, full frame in raster order, one frame_done
    do_reset();
    run = 1'b1;
    wait_ret(8, 300, "t1");
    drain("t1");
    check_streams("t1");
    chk("t1_frames", 64'(fd_cnt), 64'(1));

    // 2: slow engine 0 holds back the faster ones
    do_reset();
    set_lat(9, 2, 2, 2);
    run = 1'b1;
    step(4);
    run = 1'b0;
    drain("t2");
    chk("t2_disp_cnt", 64'(dq.size()), 64'(4));
    chk("t2_ret_cnt", 64'(rq.size()), 64'(4));
    chk("t2_first_done_eng", 64'(done_order.size() > 0 ? done_order[0] : -1), 64'(1));
    check_streams("t2");

    // 3: back-pressure stalls dispatch after NUM_ENGINES pixels
    do_reset();
    set_lat(5, 5, 5, 5);
    pix_ready = 1'b0;
    run = 1'b1;
    step(20);
    chk("t3_stall_disp", 64'(dq.size()), 64'(NE));
    chk("t3_stall_ret", 64'(rq.size()), 64'(0));
    chk("t3_hold_a", 64'({pix_valid, pix_sof, pix_x, pix_y, pix_depth}),
        64'({1'b1, 1'b1, 10'd0, 9'd0, depth_of(10'd0, 9'd0)}));
    step(5);
    chk("t3_hold_b", 64'({pix_valid, pix_sof, pix_x, pix_y, pix_depth, eng_start}),
        64'({1'b1, 1'b1, 10'd0, 9'd0, depth_of(10'd0, 9'd0), 4'd0}));
    pix_ready = 1'b1;
    wait_ret(10, 300, "t3");
    drain("t3");
    check_streams("t3");
    chk("t3_frames", 64'(fd_cnt), 64'(1));

    // 4: run dropped after three dispatches, then resumed
    do_reset();
    run = 1'b1;
    step(3);
    run = 1'b0;
    step(30);
    chk("t4_disp_cnt", 64'(dq.size()), 64'(3));
    chk("t4_ret_cnt", 64'(rq.size()), 64'(3));
    run = 1'b1;
    c = 0;
    while (dq.size() < 4 && c < 20) begin step(1); c++; end
    run = 1'b0;
    chk("t4_resume_seen", 64'(dq.size() >= 4), 64'(1));
    if (dq.size() >= 4) chk("t4_resume_xy", 64'({dq[3].x, dq[3].y}), 64'({10'd3, 9'd0}));
    drain("t4");
    check_streams("t4");

    // 5: spurious done on idle slot 2
    chk("t5_err_before", 64'(proto_err), 64'(0));
    inj = 4'b0100;
    step(1);
    inj = '0;
    chk("t5_err_set", 64'(proto_err), 64'(1));
    run = 1'b1;
    wait_ret(9, 300, "t5");
    drain("t5");
    check_streams("t5");
    chk("t5_err_sticky", 64'(proto_err), 64'(1));
    chk("t5_frames", 64'(fd_cnt), 64'(1));

    // 6: reset mid-frame drops in-flight work and restarts at (0,0)
    run = 1'b1;
    step(7);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", 64'({eng_start, eng_x, eng_y, pix_valid, pix_depth, pix_x, pix_y,
                                 pix_sof, pix_eol, frame_done, proto_err}), 64'(0));
    step(2);
    dq.delete(); rq.delete(); done_order.delete(); fd_cnt = 0;
    rst_n = 1'b1;
    c = 0;
    while (dq.size() < 1 && c < 20) begin step(1); c++; end
    chk("t6_first_seen", 64'(dq.size() >= 1), 64'(1));
    if (dq.size() >= 1) chk("t6_first_disp", 64'(dq[0]), 64'(exp_disp(0)));
    drain("t6");
    check_streams("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
